alu_result_stage: RTL and testbench

- Registered stage directly downstream of the 32-bit combinational ALU.
- Captures the ALU result `y`, its `op_code` and its flags O/C/Z/N into a small in-order FIFO, then presents them to the consumer (writeback) with a valid/ready handshake.
- Maintains the architectural flag register and a sticky overflow bit, both updated in issue order at capture time.

---
 rtl/alu_result_stage_if.sv | 41 ++++
 rtl/alu_result_stage.sv | 158 +++++++++++++++
 tb/tb_alu_result_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle between the ALU result stage and its neighbours.
// The slave modport is the stage's view. The master modport is the view of the
// environment that drives the ALU side and consumes the writeback side.
interface alu_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 2
);
  // ALU side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic [2:0]       op_code;
  logic             O;
  logic             C;
  logic             Z;
  logic             N;
  logic             flag_we;
  logic             sticky_clr;

  // Writeback side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [2:0]       out_op_code;
  logic [3:0]       out_flags;

  // Architectural status
  logic [3:0]       flags;
  logic             sticky_o;
  logic [CW-1:0]    count;

  modport slave (
    input  in_valid, y, op_code, O, C, Z, N, flag_we, sticky_clr, out_ready,
    output in_ready, out_valid, out_y, out_op_code, out_flags, flags, sticky_o, count
  );

  modport master (
    output in_valid, y, op_code, O, C, Z, N, flag_we, sticky_clr, out_ready,
    input  in_ready, out_valid, out_y, out_op_code, out_flags, flags, sticky_o, count
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered stage after the 32-bit ALU. It queues {y, op_code, O/C/Z/N} in a
// small in-order FIFO and hands the entries to writeback over valid/ready.
// The architectural flag register and the sticky overflow bit are updated at
// capture time, so they follow issue order and not drain order.
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_result_stage_if.slave bus
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [2:0]       op;
    logic [3:0]       fl;
  } entry_t;

  // Only add/sub-class ops (000..010) can report a real arithmetic overflow.
  function automatic logic is_arith_op(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010);
  endfunction

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   rd_ptr_d;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [3:0]      flags_q;
  logic [3:0]      flags_d;
  logic            sticky_q;
  logic            sticky_d;

  logic            in_ready_s;
  logic            out_valid_s;
  logic            push_s;
  logic            pop_s;
  logic            sticky_set_s;
  entry_t          in_entry_s;
  entry_t          head_s;
  logic [WIDTH-1:0] out_y_s;
  logic [2:0]      out_op_s;
  logic [3:0]      out_fl_s;

  // Handshake decode. in_ready depends only on the stored count, so a full
  // stage stalls the ALU even when writeback drains in the same cycle.
  always_comb begin
    in_ready_s   = (count_q != FULL_CNT);
    out_valid_s  = (count_q != {CW{1'b0}});
    push_s       = bus.in_valid & in_ready_s;
    pop_s        = out_valid_s & bus.out_ready;
    sticky_set_s = push_s & bus.O & is_arith_op(bus.op_code);
    in_entry_s.y  = bus.y;
    in_entry_s.op = bus.op_code;
    in_entry_s.fl = {bus.O, bus.C, bus.Z, bus.N};
  end

  // Next-state for pointers, occupancy, flag register and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    flags_d  = flags_q;
    sticky_d = sticky_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_s && bus.flag_we) begin
      flags_d = in_entry_s.fl;
    end else begin
      flags_d = flags_q;
    end

    // A set in the same cycle as a clear wins, so no overflow is ever lost.
    if (sticky_set_s) begin
      sticky_d = 1'b1;
    end else if (bus.sticky_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Control state registers. Reset discards everything held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      flags_q  <= 4'b0000;
      sticky_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
    end
  end

  // Entry storage. It is cleared on reset so no X ever reaches the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= in_entry_s;
    end
  end

  // Head presentation, decoded from registered state and forced to zero when empty.
  always_comb begin
    head_s = mem_q[rd_ptr_q];
    if (out_valid_s) begin
      out_y_s  = head_s.y;
      out_op_s = head_s.op;
      out_fl_s = head_s.fl;
    end else begin
      out_y_s  = {WIDTH{1'b0}};
      out_op_s = 3'b000;
      out_fl_s = 4'b0000;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.out_y       = out_y_s;
  assign bus.out_op_code = out_op_s;
  assign bus.out_flags   = out_fl_s;
  assign bus.flags       = flags_q;
  assign bus.sticky_o    = sticky_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage. A queue-based model predicts every
// output, a negedge process compares the DUT against the model, and literal
// checks in the stimulus pin the model to hand-computed values.
module tb_alu_result_stage;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 2;

  typedef struct packed {
    logic [31:0] y;
    logic [2:0]  op;
    logic [3:0]  fl;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  bit   chk_en;

  ent_t        mq[$];
  logic [3:0]  m_flags;
  logic        m_sticky;

  alu_result_stage_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one clock edge of the stage expressed as queue operations.
  task automatic model_step();
    bit do_push;
    bit do_pop;
    ent_t e;
    do_pop  = (mq.size() != 0) && (bus.out_ready === 1'b1);
    do_push = (bus.in_valid === 1'b1) && (mq.size() < DEPTH);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      e.y  = bus.y;
      e.op = bus.op_code;
      e.fl = {bus.O, bus.C, bus.Z, bus.N};
      mq.push_back(e);
      if (bus.flag_we) m_flags = e.fl;
    end
    if (do_push && bus.O && (bus.op_code inside {3'b000, 3'b001, 3'b010}))
      m_sticky = 1'b1;
    else if (bus.sticky_clr)
      m_sticky = 1'b0;
  endtask

  // Drive one cycle of inputs, let the clock edge happen, then advance the model.
  task automatic drive(input logic v, input logic [31:0] yy, input logic [2:0] op,
                       input logic [3:0] f, input logic fwe, input logic sclr,
                       input logic ordy);
    bus.in_valid   = v;
    bus.y          = yy;
    bus.op_code    = op;
    {bus.O, bus.C, bus.Z, bus.N} = f;
    bus.flag_we    = fwe;
    bus.sticky_clr = sclr;
    bus.out_ready  = ordy;
    @(posedge clk);
    #1;
    model_step();
  endtask

  // Compare DUT against model on every falling edge outside reset.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("in_ready",  bus.in_ready,  (mq.size() != DEPTH));
      chk("out_valid", bus.out_valid, (mq.size() != 0));
      chk("count",     bus.count,     mq.size());
      chk("flags",     bus.flags,     m_flags);
      chk("sticky_o",  bus.sticky_o,  m_sticky);
      if (mq.size() != 0) begin
        chk("out_y",       bus.out_y,       mq[0].y);
        chk("out_op_code", bus.out_op_code, mq[0].op);
        chk("out_flags",   bus.out_flags,   mq[0].fl);
      end
    end
  end

  initial begin
    n_cmp = 0; n_fail = 0; chk_en = 1'b0;
    m_flags = 4'b0000; m_sticky = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.y = 32'h0; bus.op_code = 3'b000;
    bus.O = 1'b0; bus.C = 1'b0; bus.Z = 1'b0; bus.N = 1'b0;
    bus.flag_we = 1'b0; bus.sticky_clr = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_count",     bus.count,     2'd0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_y",     bus.out_y,     32'h0);
    chk("rst_flags",     bus.flags,     4'b0000);
    chk("rst_sticky",    bus.sticky_o,  1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Single push, one-cycle latency, drained immediately
    drive(1'b1, 32'h0000_0005, 3'b000, 4'b0000, 1'b1, 1'b0, 1'b1);
    chk("lat_out_valid", bus.out_valid, 1'b1);
    chk("lat_out_y",     bus.out_y,     32'h5);
    drive(1'b0, 32'h0, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("lat_count0",    bus.count,     2'd0);

    // Fill, overflow attempt, drain in order
    drive(1'b1, 32'h11, 3'b001, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("fill_count1",   bus.count,     2'd1);
    drive(1'b1, 32'h22, 3'b010, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("fill_in_ready", bus.in_ready,  1'b0);
    chk("fill_count2",   bus.count,     2'd2);
    drive(1'b1, 32'h33, 3'b011, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("full_head",     bus.out_y,     32'h11);
    drive(1'b1, 32'h33, 3'b011, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("drain_count1",  bus.count,     2'd1);
    chk("drain_head22",  bus.out_y,     32'h22);
    drive(1'b0, 32'h0, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("drain_count0",  bus.count,     2'd0);

    // Simultaneous push/pop at count 1, wrapping pointers
    drive(1'b1, 32'h100, 3'b111, 4'b0101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 3'(i), 4'(i), 1'b0, 1'b0, 1'b1);
      chk("pp_count",  bus.count, 2'd1);
      chk("pp_head",   bus.out_y, 32'h200 + 32'(i));
    end
    drive(1'b0, 32'h0, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b1);

    // Sticky overflow behaviour
    drive(1'b1, 32'h8000_0000, 3'b000, 4'b1001, 1'b1, 1'b0, 1'b1);
    chk("ovf_sticky",    bus.sticky_o,  1'b1);
    chk("ovf_flags",     bus.flags,     4'b1001);
    drive(1'b1, 32'h0, 3'b010, 4'b0000, 1'b0, 1'b1, 1'b1);
    chk("clr_sticky_a",  bus.sticky_o,  1'b0);
    drive(1'b1, 32'h8000_0000, 3'b000, 4'b1001, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'hFFFF_FFFF, 3'b011, 4'b1001, 1'b0, 1'b0, 1'b1);
    chk("logic_o_sticky", bus.sticky_o, 1'b1);
    drive(1'b1, 32'h7FFF_FFFF, 3'b001, 4'b1000, 1'b0, 1'b1, 1'b1);
    chk("setwins_sticky", bus.sticky_o, 1'b1);
    drive(1'b0, 32'h0, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b1);
    chk("clr_sticky",    bus.sticky_o,  1'b0);
    drive(1'b1, 32'h1, 3'b011, 4'b1000, 1'b0, 1'b0, 1'b1);
    chk("logic_o_only",  bus.sticky_o,  1'b0);

    // Flag write enable
    drive(1'b1, 32'h0, 3'b001, 4'b0010, 1'b0, 1'b0, 1'b1);
    chk("fwe0_flags",    bus.flags,     4'b1001);
    drive(1'b0, 32'h0, 3'b001, 4'b0110, 1'b1, 1'b0, 1'b1);
    chk("fwe_nopush",    bus.flags,     4'b1001);
    drive(1'b1, 32'h0, 3'b001, 4'b0010, 1'b1, 1'b0, 1'b1);
    chk("fwe1_flags",    bus.flags,     4'b0010);
    drive(1'b0, 32'h0, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("pop_flags",     bus.flags,     4'b0010);

    // Asynchronous reset while holding two entries
    drive(1'b1, 32'hAA, 3'b100, 4'b0100, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'hBB, 3'b101, 4'b0001, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_count", bus.count,     2'd2);
    bus.in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_count",     bus.count,       2'd0);
    chk("arst_out_valid", bus.out_valid,   1'b0);
    chk("arst_out_y",     bus.out_y,       32'h0);
    chk("arst_out_op",    bus.out_op_code, 3'b000);
    chk("arst_out_flags", bus.out_flags,   4'b0000);
    chk("arst_flags",     bus.flags,       4'b0000);
    mq.delete();
    m_flags = 4'b0000;
    m_sticky = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 32'hCC, 3'b110, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("post_rst_head",  bus.out_y,     32'hCC);
    drive(1'b1, 32'hDD, 3'b111, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("post_rst_next",  bus.out_y,     32'hDD);
    drive(1'b0, 32'h0, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("post_rst_empty", bus.count,     2'd0);

    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
